// File: rtl/hit_event_pkg.sv
// hit_event_pkg: shared game state encoding, widths and popcount helper for the hit event manager
package hit_event_pkg;
  typedef enum logic [1:0] {PLAY = 2'd0, COOLDOWN = 2'd1, GAME_OVER = 2'd2} game_state_t;
  localparam int NUM_SHOTS = 3;
  localparam int SCORE_W = 14;
  localparam int LIVES_W = 3;
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/frame_event_latch.sv
// frame_event_latch: one frame flag turning a level collision into one pulse per frame; ports clk, reset, startOfFrame, hit_in -> pulse_out (registered, or the same-cycle fire when EARLY=1)
module frame_event_latch #(
  parameter bit EARLY = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic hit_in,
  output logic pulse_out
);
  logic flag, fire, pulse_r;
  // a collision on the frame-start cycle belongs to the new frame
  assign fire = hit_in & (~flag | startOfFrame);
  // the player FSM consumes the fire in-cycle so its own outputs stay one cycle behind
  assign pulse_out = EARLY ? fire : pulse_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      flag    <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      flag    <= startOfFrame ? hit_in : (flag | hit_in);
      pulse_r <= fire;
    end
  end
endmodule

// File: rtl/hit_event_manager.sv
// hit_event_manager: per-frame collision events, lives/cooldown/score and PLAY/COOLDOWN/GAME_OVER FSM; inputs clk, reset, startOfFrame, collision levels; outputs event pulses, lives, score, state, player_visible; optional macro INVULN_BLINK_EN blinks the player during cooldown
import hit_event_pkg::*;
module hit_event_manager #(
  parameter int START_LIVES     = 3,
  parameter int INVULN_FRAMES   = 30,
  parameter int SCORE_PER_ENEMY = 10,
  parameter int SCORE_MAX       = 9999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         startOfFrame,
  input  logic [2:0]   ShotBoxCollision,
  input  logic         TowerEnemyHUCollision,
  input  logic [2:0]   ShotEnemyCollision,
  input  logic         towerPlayerCollision,
  output logic [2:0]   shot_tower_hit,
  output logic [2:0]   shot_enemy_hit,
  output logic         enemy_hu_tower_hit,
  output logic         player_hit,
  output logic [2:0]   lives,
  output logic [13:0]  score,
  output logic [1:0]   state,
  output logic         player_visible
);
  localparam int SW1 = SCORE_W + 1;
  localparam logic [SW1-1:0] SMAX = SW1'(SCORE_MAX);
  logic [2:0] st_r, se_r;
  logic hu_r, pt_fire, ph_r, go;
  logic [SW1-1:0] sum;
  logic [7:0] cnt;
  game_state_t st;
  genvar i;
  for (i = 0; i < NUM_SHOTS; i++) begin : g_shot
    frame_event_latch u_st (.clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_in(ShotBoxCollision[i]), .pulse_out(st_r[i]));
    frame_event_latch u_se (.clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_in(ShotEnemyCollision[i]), .pulse_out(se_r[i]));
  end
  frame_event_latch u_hu (.clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_in(TowerEnemyHUCollision), .pulse_out(hu_r));
  frame_event_latch #(.EARLY(1'b1)) u_pt (.clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_in(towerPlayerCollision), .pulse_out(pt_fire));
  assign go = st == GAME_OVER;
  assign state = st;
  assign shot_tower_hit = go ? 3'b0 : st_r;
  assign shot_enemy_hit = go ? 3'b0 : se_r;
  assign enemy_hu_tower_hit = hu_r & ~go;
  // the fatal hit's pulse lands in GAME_OVER and is masked with everything else
  assign player_hit = ph_r & ~go;
  assign sum = SW1'(score) + SW1'(popcount3(shot_enemy_hit) * SCORE_PER_ENEMY);
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= PLAY;
      lives <= LIVES_W'(START_LIVES);
      score <= '0;
      cnt   <= '0;
      ph_r  <= 1'b0;
    end else begin
      ph_r <= st == PLAY && pt_fire && lives != '0;
      if (!go) score <= sum > SMAX ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
      if (st == PLAY && pt_fire && lives != '0) begin
        lives <= lives - 1'b1;
        st    <= lives == LIVES_W'(1) ? GAME_OVER : COOLDOWN;
        cnt   <= 8'(INVULN_FRAMES);
      end else if (st == COOLDOWN && startOfFrame) begin
        cnt <= cnt - 1'b1;
        if (cnt == 8'd1) st <= PLAY;
      end
    end
  end
`ifdef INVULN_BLINK_EN
  logic [1:0] bcnt;
  logic vis;
  // held at visible/zero outside COOLDOWN so every cooldown starts visible
  always_ff @(posedge clk) begin
    if (reset || st != COOLDOWN) begin
      bcnt <= 2'd0;
      vis  <= 1'b1;
    end else if (startOfFrame) begin
      bcnt <= bcnt + 1'b1;
      if (bcnt == 2'd3) vis <= ~vis;
    end
  end
  assign player_visible = st == PLAY || (st == COOLDOWN && vis);
`else
  assign player_visible = ~go;
`endif
endmodule

// File: tb/tb_hit_event_manager.sv
// tb_hit_event_manager: directed and randomized checks of hit_event_manager against a frame-level reference model
module tb_hit_event_manager;
  logic clk = 1'b0, reset = 1'b1, startOfFrame = 1'b0;
  logic [2:0] ShotBoxCollision = '0, ShotEnemyCollision = '0;
  logic TowerEnemyHUCollision = 1'b0, towerPlayerCollision = 1'b0;
  logic [2:0] shot_tower_hit, shot_enemy_hit, lives;
  logic enemy_hu_tower_hit, player_hit, player_visible;
  logic [13:0] score;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  logic [7:0] seen;
  int m_lives, m_score, m_st, m_frames_left, m_cd_frames;
  logic [2:0] e_st, e_se;
  logic e_hu, e_ph;

  hit_event_manager #(.INVULN_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .ShotBoxCollision(ShotBoxCollision), .TowerEnemyHUCollision(TowerEnemyHUCollision),
    .ShotEnemyCollision(ShotEnemyCollision), .towerPlayerCollision(towerPlayerCollision),
    .shot_tower_hit(shot_tower_hit), .shot_enemy_hit(shot_enemy_hit),
    .enemy_hu_tower_hit(enemy_hu_tower_hit), .player_hit(player_hit),
    .lives(lives), .score(score), .state(state), .player_visible(player_visible)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // game rules at frame granularity: one event per source per frame, 3 lives, 2 frames of invulnerability
  task automatic model_step();
    logic [7:0] in, fires;
    int old_st;
    if (reset) begin
      seen = '0; m_lives = 3; m_score = 0; m_st = 0; m_frames_left = 0; m_cd_frames = 0;
      e_st = '0; e_se = '0; e_hu = 1'b0; e_ph = 1'b0;
      return;
    end
    in = {towerPlayerCollision, TowerEnemyHUCollision, ShotEnemyCollision, ShotBoxCollision};
    fires = startOfFrame ? in : (in & ~seen);
    seen = startOfFrame ? in : (seen | in);
    old_st = m_st;
    if (old_st != 2) m_score = (m_score + 10 * $countones(e_se) > 9999) ? 9999 : m_score + 10 * $countones(e_se);
    e_ph = 1'b0;
    if (old_st == 0 && fires[7]) begin
      m_lives = m_lives - 1;
      e_ph = 1'b1;
      if (m_lives == 0) m_st = 2;
      else begin m_st = 1; m_frames_left = 2; m_cd_frames = 0; end
    end else if (old_st == 1 && startOfFrame) begin
      m_frames_left--;
      m_cd_frames++;
      if (m_frames_left == 0) m_st = 0;
    end
    e_st = m_st == 2 ? 3'b0 : fires[2:0];
    e_se = m_st == 2 ? 3'b0 : fires[5:3];
    e_hu = m_st != 2 && fires[6];
    e_ph = m_st != 2 && e_ph;
  endtask

  function automatic logic exp_visible();
`ifdef INVULN_BLINK_EN
    if (m_st == 1) return ((m_cd_frames / 4) % 2) == 0;
`endif
    return m_st != 2;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("shot_tower_hit", shot_tower_hit, e_st);
    chk("shot_enemy_hit", shot_enemy_hit, e_se);
    chk("enemy_hu_tower_hit", enemy_hu_tower_hit, e_hu);
    chk("player_hit", player_hit, e_ph);
    chk("lives", lives, m_lives);
    chk("score", score, m_score);
    chk("state", state, m_st);
    chk("player_visible", player_visible, exp_visible());
  endtask

  initial begin
    int pulses;
    step(); step();
    reset = 1'b0;
    chk("reset_lives", lives, 3);
    chk("reset_score", score, 0);
    chk("reset_state", state, 0);
    chk("reset_visible", player_visible, 1);
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    ShotEnemyCollision = 3'b010;
    pulses = 0;
    repeat (20) begin step(); if (shot_enemy_hit == 3'b010) pulses++; end
    ShotEnemyCollision = 3'b000;
    step(); step();
    chk("single_shot_one_pulse", pulses, 1);
    chk("single_shot_score", score, 10);
    startOfFrame = 1'b1; ShotEnemyCollision = 3'b101; step(); startOfFrame = 1'b0;
    chk("two_shot_pulse", shot_enemy_hit, 3'b101);
    step();
    chk("two_shot_once", shot_enemy_hit, 3'b000);
    step(); step();
    chk("two_shot_score", score, 30);
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    chk("sof_coincident_pulse", shot_enemy_hit, 3'b101);
    ShotEnemyCollision = 3'b000;
    step(); step();
    chk("sof_coincident_score", score, 50);
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    towerPlayerCollision = 1'b1; step();
    chk("hit_pulse", player_hit, 1);
    chk("hit_lives", lives, 2);
    chk("hit_state", state, 1);
    repeat (3) step();
    chk("cooldown_ignored", lives, 2);
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step();
    chk("cooldown_frame1", state, 1);
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    chk("cooldown_exit_state", state, 0);
    chk("cooldown_exit_ignored", lives, 2);
    step();
    towerPlayerCollision = 1'b0; startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    towerPlayerCollision = 1'b1; step(); towerPlayerCollision = 1'b0;
    chk("second_hit_lives", lives, 1);
    chk("second_hit_state", state, 1);
    chk("pre_reset_score", score, 50);
    ShotEnemyCollision = 3'b111; startOfFrame = 1'b1; reset = 1'b1; step();
    reset = 1'b0; startOfFrame = 1'b0; ShotEnemyCollision = 3'b000;
    chk("mid_reset_lives", lives, 3);
    chk("mid_reset_score", score, 0);
    chk("mid_reset_state", state, 0);
    chk("mid_reset_pulse", shot_enemy_hit, 0);
    for (int h = 0; h < 3; h++) begin
      startOfFrame = 1'b1; towerPlayerCollision = 1'b1; step();
      startOfFrame = 1'b0; towerPlayerCollision = 1'b0; step();
      repeat (2) begin startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step(); end
    end
    chk("gameover_lives", lives, 0);
    chk("gameover_state", state, 2);
    chk("gameover_visible", player_visible, 0);
    ShotBoxCollision = 3'b111; ShotEnemyCollision = 3'b111;
    TowerEnemyHUCollision = 1'b1; towerPlayerCollision = 1'b1;
    repeat (4) begin startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step(); end
    chk("gameover_no_pulse", shot_enemy_hit, 0);
    chk("gameover_score", score, 0);
    chk("gameover_sticky", state, 2);
    ShotBoxCollision = '0; TowerEnemyHUCollision = 1'b0; towerPlayerCollision = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    repeat (800) begin startOfFrame = ~startOfFrame; step(); end
    chk("score_saturate", score, 9999);
    ShotEnemyCollision = '0; startOfFrame = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      startOfFrame = (c % 8) == 0;
      ShotBoxCollision = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      ShotEnemyCollision = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      TowerEnemyHUCollision = $urandom_range(0, 3) == 0;
      towerPlayerCollision = $urandom_range(0, 5) == 0;
      reset = $urandom_range(0, 149) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
